// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode and sequencer state types for the ALU execution path
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_AND    = 3'd2,
        OP_OR     = 3'd3,
        OP_XOR    = 3'd4,
        OP_SHL    = 3'd5,
        OP_SHR    = 3'd6,
        OP_PASS_A = 3'd7
    } alu_op_t;

    typedef enum logic [2:0] {
        S_FETCH_OP = 3'd0,
        S_FETCH_A  = 3'd1,
        S_FETCH_B  = 3'd2,
        S_EXEC     = 3'd3,
        S_HOLD     = 3'd4
    } seq_state_t;

    // States in which the sequencer is allowed to consume FIFO words.
    function automatic logic is_fetch_state(input seq_state_t s);
        return (s == S_FETCH_OP) || (s == S_FETCH_A) || (s == S_FETCH_B);
    endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU: (op, a, b) -> (y, carry, zero, overflow)
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  alu_op_t           i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_y,
    output logic              o_c,
    output logic              o_z,
    output logic              o_v
);

    localparam int SH_W = $clog2(DATA_W);

    // Extra top bit captures carry-out on add and borrow (A < B) on subtract.
    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    // Opcode decode; carry and overflow are only meaningful for ADD/SUB.
    always_comb begin
        o_y = '0;
        o_c = 1'b0;
        o_v = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_y = w_sum[DATA_W-1:0];
                o_c = w_sum[DATA_W];
                o_v = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (o_y[DATA_W-1] != i_a[DATA_W-1]);
            end
            OP_SUB: begin
                o_y = w_diff[DATA_W-1:0];
                o_c = w_diff[DATA_W];
                o_v = (i_a[DATA_W-1] != i_b[DATA_W-1]) && (o_y[DATA_W-1] != i_a[DATA_W-1]);
            end
            OP_AND:    o_y = i_a & i_b;
            OP_OR:     o_y = i_a | i_b;
            OP_XOR:    o_y = i_a ^ i_b;
            OP_SHL:    o_y = i_a << i_b[SH_W-1:0];
            OP_SHR:    o_y = i_a >> i_b[SH_W-1:0];
            OP_PASS_A: o_y = i_a;
            default:   o_y = i_a;
        endcase
    end

    assign o_z = (o_y == '0);

endmodule

// File: rtl/alu_exec_sequencer.sv
// rtl/alu_exec_sequencer.sv - pops opcode/A/B records from the FIFO, executes them, holds result
module alu_exec_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              pop,
    output logic [DATA_W-1:0] result,
    output logic              result_carry,
    output logic              result_zero,
    output logic              result_ovf,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy,
    output logic              rec_error,
    output logic [CNT_W-1:0]  op_count
);

    localparam int ST_W = $clog2(TIMEOUT);

    seq_state_t        r_state;
    seq_state_t        w_next;
    alu_op_t           r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [ST_W-1:0]   r_stall;
    logic [DATA_W-1:0] r_result;
    logic              r_carry;
    logic              r_zero;
    logic              r_ovf;
    logic              r_valid;
    logic              r_rec_error;
    logic [CNT_W-1:0]  r_op_count;

    logic              w_pop;
    logic              w_stalled;
    logic              w_timeout;
    logic              w_accept;
    logic [DATA_W-1:0] w_y;
    logic              w_c;
    logic              w_z;
    logic              w_v;

    alu_core #(.DATA_W(DATA_W)) u_alu_core (
        .i_op (r_op),
        .i_a  (r_a),
        .i_b  (r_b),
        .o_y  (w_y),
        .o_c  (w_c),
        .o_z  (w_z),
        .o_v  (w_v)
    );

    // Only mid-record waits are bounded; an idle FETCH_OP may wait forever.
    assign w_stalled = fifo_empty && ((r_state == S_FETCH_A) || (r_state == S_FETCH_B));
    assign w_timeout = w_stalled && (r_stall == ST_W'(TIMEOUT - 1));
    assign w_accept  = r_valid && result_ready && (r_state == S_HOLD);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH_OP;
        else       r_state <= w_next;
    end

    // Next-state: linear fetch/exec/hold walk, with timeout abort from the operand fetches.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH_OP: if (w_pop) w_next = S_FETCH_A;
            S_FETCH_A: begin
                if (w_pop)          w_next = S_FETCH_B;
                else if (w_timeout) w_next = S_FETCH_OP;
            end
            S_FETCH_B: begin
                if (w_pop)          w_next = S_EXEC;
                else if (w_timeout) w_next = S_FETCH_OP;
            end
            S_EXEC:     w_next = S_HOLD;
            S_HOLD:     if (w_accept) w_next = S_FETCH_OP;
            default:    w_next = S_FETCH_OP;
        endcase
    end

    // Outputs decoded from state; pop is suppressed during reset so no word is lost to it.
    always_comb begin
        w_pop = !reset && !fifo_empty && is_fetch_state(r_state);
        pop   = w_pop;
        busy  = (r_state != S_FETCH_OP);
    end

    // Latch the record fields as each word is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op <= OP_ADD;
            r_a  <= '0;
            r_b  <= '0;
        end else if (w_pop) begin
            case (r_state)
                S_FETCH_OP: r_op <= alu_op_t'(fifo_rd_data[2:0]);
                S_FETCH_A:  r_a  <= fifo_rd_data;
                S_FETCH_B:  r_b  <= fifo_rd_data;
                default:    r_op <= r_op;
            endcase
        end
    end

    // Consecutive-empty counter; any pop, non-stall cycle or abort restarts it.
    always_ff @(posedge clk) begin
        if (reset || !w_stalled || w_timeout) r_stall <= '0;
        else                                  r_stall <= r_stall + 1'b1;
    end

    // One-cycle abort pulse following the timeout cycle.
    always_ff @(posedge clk) begin
        if (reset) r_rec_error <= 1'b0;
        else       r_rec_error <= w_timeout;
    end

    // Result and flags captured in EXEC and retained until the next EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_result <= w_y;
            r_carry  <= w_c;
            r_zero   <= w_z;
            r_ovf    <= w_v;
        end
    end

    // Valid handshake and accepted-result counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_op_count <= '0;
        end else begin
            if (r_state == S_EXEC) r_valid <= 1'b1;
            else if (w_accept)     r_valid <= 1'b0;
            if (w_accept)          r_op_count <= r_op_count + 1'b1;
        end
    end

    assign result       = r_result;
    assign result_carry = r_carry;
    assign result_zero  = r_zero;
    assign result_ovf   = r_ovf;
    assign result_valid = r_valid;
    assign rec_error    = r_rec_error;
    assign op_count     = r_op_count;

endmodule
